hazard_unit_mc: RTL and testbench
=================================

Name: hazard_unit_mc

Overview:
- Parametrised hazard/forwarding controller for the 5-stage MIPS pipeline (F/D/E/M/W).
- Adds a variable-latency multiply/divide unit (HI/LO) busy tracker.
- Adds a data-memory wait handshake with a timeout watchdog.
- Drives every stall/flush/forward select; sits beside the datapath, fed by pipeline-register fields.

Parameters:
- REG_AW, 5, register-address width; register 0 is hardwired zero.
- MD_LATENCY, 32, cycles mult/div occupies HI/LO after issue from E (>=1).
- MEM_TIMEOUT, 255, consecutive memory-wait cycles before mem_err sets (>=1).

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- rs_d, rt_d  in  REG_AW  D-stage source registers
- rs_e, rt_e  in  REG_AW  E-stage source registers
- wreg_e, wreg_m, wreg_w  in  REG_AW  destination register per stage
- regwrite_e, regwrite_m, regwrite_w  in  1  stage writes register file
- memtoreg_e, memtoreg_m  in  1  stage holds a load
- branch_d  in  1  conditional branch in D (compares rs, rt)
- jumpr_d  in  1  jr/jalr in D (uses rs only)
- md_op_d  in  1  mult/div in D
- md_read_d  in  1  mfhi/mflo in D
- md_start_e  in  1  mult/div in E (issues this cycle unless stalled)
- dmem_req_m  in  1  M-stage memory access active
- dmem_ready_m  in  1  memory completes access this cycle
- stall_f, stall_d, stall_e, stall_m  out  1  hold pipeline register
- flush_e, flush_w  out  1  insert bubble into E / W
- fwd_a_d, fwd_b_d  out  2  D compare operand select: 00 regfile, 10 M ALU result, 01 W result
- fwd_a_e, fwd_b_e  out  2  E operand select, same encoding
- md_busy  out  1  HI/LO result pending
- mem_err  out  1  sticky memory timeout flag

Behaviour:
- State: md_cnt (counts MD_LATENCY..0), to_cnt (0..MEM_TIMEOUT), mem_err. Async reset clears all three.
- While rst_n low, every output is 0.
- Operand match: m(x,w,we) = we && w!=0 && w==x.
- E forwarding: fwd_a_e = 10 if m(rs_e,wreg_m,regwrite_m); else 01 if m(rs_e,wreg_w,regwrite_w); else 00. fwd_b_e is identical using rt_e. M has priority over W.
- D forwarding: active only when branch_d||jumpr_d, else 00. Select 10 if m(rs_d,wreg_m,regwrite_m) && !memtoreg_m; else 01 if m(rs_d,wreg_w,regwrite_w). B side uses rt_d and only with branch_d.
- Decode hazards:
  - Consumed registers: uses_rs = 1; uses_rt = 1 except under jumpr_d.
  - lw_stall = memtoreg_e && any consumed D source matches wreg_e (wreg_e != 0).
  - br_stall = (branch_d||jumpr_d) && (m(src,wreg_e,regwrite_e) || m(src,wreg_m,memtoreg_m)) for a consumed source.
  - md_stall = (md_op_d||md_read_d) && (md_busy || md_start_e).
- mem_wait = dmem_req_m && !dmem_ready_m.
- Output priority:
  - mem_wait: stall_f=stall_d=stall_e=stall_m=1, flush_w=1, flush_e=0.
  - else any decode hazard: stall_f=stall_d=1, flush_e=1.
  - else all stalls/flushes 0.
- md_cnt:
  - md_start_e && !stall_e: load MD_LATENCY. This overrides a nonzero count and restarts; the restart case is unreachable given md_stall.
  - else if md_cnt != 0: decrement. Decrement continues during memory stalls.
  - md_busy = (md_cnt != 0), registered-state decode.
- md_start_e held under stall_e does not load; it loads in the first unstalled cycle.
- Watchdog:
  - to_cnt increments each mem_wait cycle, saturating at MEM_TIMEOUT; clears on any cycle without mem_wait.
  - mem_err sets on the edge where to_cnt == MEM_TIMEOUT-1 and mem_wait holds. It stays set until reset and does not alter stall behaviour.

Test Plan:
- E forwarding, both stages hit: wreg_m=wreg_w=rs_e=5, regwrite_m=regwrite_w=1 -> fwd_a_e=10. Then drop regwrite_m -> 01. Then rs_e=0 -> 00.
- Load-use: memtoreg_e=1, wreg_e=rt_d=8 -> stall_f=stall_d=flush_e=1 for exactly one cycle, then 0 after the load advances to M.
- Branch after ALU write: branch_d=1, rs_d=wreg_e=3, regwrite_e=1 -> one-cycle stall. Next cycle fwd_a_d=10, no stall. If the producer is a load, expect two stall cycles.
- Mult/div (MD_LATENCY=4): md_start_e pulse, then md_read_d held -> md_busy high 4 cycles, stall_d high in those cycles plus the issue cycle, released when md_cnt reaches 0.
- Memory wait (MEM_TIMEOUT=3): dmem_req_m=1, dmem_ready_m=0 for 5 cycles -> stall_f..stall_m and flush_w high throughout; mem_err rises after the 3rd cycle. Assert ready -> stalls drop that cycle, mem_err stays 1.
- Mid-operation reset: assert rst_n=0 with md_cnt=2 and mem_err=1 -> all outputs 0 immediately, asynchronously. After release, md_busy=0 and mem_err=0.

Source files
------------

// File: rtl/hazard_unit_mc_if.sv
// Pipeline-field / control bundle between the datapath and the hazard unit.
// The datapath drives register fields and stage flags; the hazard unit answers with stall/flush/forward selects.
interface hazard_unit_mc_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] rs_d, rt_d, rs_e, rt_e;
  logic [REG_AW-1:0] wreg_e, wreg_m, wreg_w;
  logic              regwrite_e, regwrite_m, regwrite_w;
  logic              memtoreg_e, memtoreg_m;
  logic              branch_d, jumpr_d;
  logic              md_op_d, md_read_d, md_start_e;
  logic              dmem_req_m, dmem_ready_m;
  logic              stall_f, stall_d, stall_e, stall_m;
  logic              flush_e, flush_w;
  logic [1:0]        fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e;
  logic              md_busy, mem_err;

  modport master (
    output rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w,
           regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m,
           branch_d, jumpr_d, md_op_d, md_read_d, md_start_e,
           dmem_req_m, dmem_ready_m,
    input  stall_f, stall_d, stall_e, stall_m, flush_e, flush_w,
           fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e, md_busy, mem_err
  );

  modport slave (
    input  rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w,
           regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m,
           branch_d, jumpr_d, md_op_d, md_read_d, md_start_e,
           dmem_req_m, dmem_ready_m,
    output stall_f, stall_d, stall_e, stall_m, flush_e, flush_w,
           fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e, md_busy, mem_err
  );
endinterface

// File: rtl/hazard_unit_mc.sv
// Hazard/forwarding controller for a 5-stage MIPS pipeline with a
// variable-latency HI/LO busy tracker and a data-memory wait watchdog.
module hazard_unit_mc #(
  parameter int REG_AW      = 5,
  parameter int MD_LATENCY  = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst_n,
  hazard_unit_mc_if.slave   hif
);
  localparam int MW = $clog2(MD_LATENCY + 1);
  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  logic [MW-1:0] md_cnt_q, md_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          mem_err_q, mem_err_d;

  logic       md_busy, mem_wait, ctrl_d, uses_rt;
  logic       lw_stall, br_stall, md_stall, dec_hazard;
  logic       stall_fd, stall_em, flush_e_i;
  logic [1:0] fwd_a_e_i, fwd_b_e_i, fwd_a_d_i, fwd_b_d_i;

  function automatic logic match(input logic [REG_AW-1:0] x,
                                 input logic [REG_AW-1:0] w,
                                 input logic              we);
    return we && (w != '0) && (w == x);
  endfunction

  function automatic logic src_hot(input logic [REG_AW-1:0] s,
                                   input logic [REG_AW-1:0] we_reg,
                                   input logic              we_wr,
                                   input logic [REG_AW-1:0] wm_reg,
                                   input logic              wm_ld);
    return match(s, we_reg, we_wr) || match(s, wm_reg, wm_ld);
  endfunction

  always_comb begin
    fwd_a_e_i = 2'b00;
    fwd_b_e_i = 2'b00;
    fwd_a_d_i = 2'b00;
    fwd_b_d_i = 2'b00;
    if (match(hif.rs_e, hif.wreg_m, hif.regwrite_m))      fwd_a_e_i = 2'b10;
    else if (match(hif.rs_e, hif.wreg_w, hif.regwrite_w)) fwd_a_e_i = 2'b01;
    if (match(hif.rt_e, hif.wreg_m, hif.regwrite_m))      fwd_b_e_i = 2'b10;
    else if (match(hif.rt_e, hif.wreg_w, hif.regwrite_w)) fwd_b_e_i = 2'b01;
    // A load result in M is not yet available to the D-stage comparator.
    if (hif.branch_d || hif.jumpr_d) begin
      if (match(hif.rs_d, hif.wreg_m, hif.regwrite_m) && !hif.memtoreg_m)  fwd_a_d_i = 2'b10;
      else if (match(hif.rs_d, hif.wreg_w, hif.regwrite_w))                fwd_a_d_i = 2'b01;
    end
    if (hif.branch_d) begin
      if (match(hif.rt_d, hif.wreg_m, hif.regwrite_m) && !hif.memtoreg_m)  fwd_b_d_i = 2'b10;
      else if (match(hif.rt_d, hif.wreg_w, hif.regwrite_w))                fwd_b_d_i = 2'b01;
    end
  end

  always_comb begin
    md_busy  = (md_cnt_q != '0);
    mem_wait = hif.dmem_req_m && !hif.dmem_ready_m;
    ctrl_d   = hif.branch_d || hif.jumpr_d;
    uses_rt  = !hif.jumpr_d;
    lw_stall = hif.memtoreg_e && (hif.wreg_e != '0) &&
               ((hif.rs_d == hif.wreg_e) || (uses_rt && (hif.rt_d == hif.wreg_e)));
    br_stall = ctrl_d &&
               (src_hot(hif.rs_d, hif.wreg_e, hif.regwrite_e, hif.wreg_m, hif.memtoreg_m) ||
                (uses_rt && src_hot(hif.rt_d, hif.wreg_e, hif.regwrite_e, hif.wreg_m, hif.memtoreg_m)));
    md_stall   = (hif.md_op_d || hif.md_read_d) && (md_busy || hif.md_start_e);
    dec_hazard = lw_stall || br_stall || md_stall;
    stall_em   = mem_wait;
    stall_fd   = mem_wait || dec_hazard;
    flush_e_i  = !mem_wait && dec_hazard;
  end

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (hif.md_start_e && !stall_em) md_cnt_d = MW'(MD_LATENCY);
    else if (md_cnt_q != '0)         md_cnt_d = md_cnt_q - 1'b1;

    to_cnt_d = '0;
    if (mem_wait) to_cnt_d = (to_cnt_q == TW'(MEM_TIMEOUT)) ? to_cnt_q : to_cnt_q + 1'b1;
    mem_err_d = mem_err_q || (mem_wait && (to_cnt_q == TW'(MEM_TIMEOUT - 1)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt_q  <= '0;
      to_cnt_q  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      md_cnt_q  <= md_cnt_d;
      to_cnt_q  <= to_cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Outputs are forced low for as long as reset is held, without waiting for a clock.
  always_comb begin
    hif.stall_f = 1'b0;
    hif.stall_d = 1'b0;
    hif.stall_e = 1'b0;
    hif.stall_m = 1'b0;
    hif.flush_e = 1'b0;
    hif.flush_w = 1'b0;
    hif.fwd_a_d = 2'b00;
    hif.fwd_b_d = 2'b00;
    hif.fwd_a_e = 2'b00;
    hif.fwd_b_e = 2'b00;
    hif.md_busy = 1'b0;
    hif.mem_err = 1'b0;
    if (rst_n) begin
      hif.stall_f = stall_fd;
      hif.stall_d = stall_fd;
      hif.stall_e = stall_em;
      hif.stall_m = stall_em;
      hif.flush_e = flush_e_i;
      hif.flush_w = mem_wait;
      hif.fwd_a_d = fwd_a_d_i;
      hif.fwd_b_d = fwd_b_d_i;
      hif.fwd_a_e = fwd_a_e_i;
      hif.fwd_b_e = fwd_b_e_i;
      hif.md_busy = md_busy;
      hif.mem_err = mem_err_q;
    end
  end
endmodule

// File: tb/tb_hazard_unit_mc.sv
// Self-checking bench for hazard_unit_mc: directed scenarios followed by randomized
// pipeline fields, all compared against a cycle-level reference model.
module tb_hazard_unit_mc;
  localparam int AW  = 5;
  localparam int LAT = 4;
  localparam int TMO = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  // Reference state: HI/LO busy through cycle busy_until; wait_run = consecutive wait cycles.
  int   cycle = 0;
  int   busy_until = -1;
  int   wait_run = 0;
  logic err_m = 1'b0;

  hazard_unit_mc_if #(.REG_AW(AW)) bus ();

  hazard_unit_mc #(.REG_AW(AW), .MD_LATENCY(LAT), .MEM_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hif   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic hit(input logic [AW-1:0] x, input logic [AW-1:0] w, input logic we);
    return we && (w != 0) && (w == x);
  endfunction

  function automatic logic [1:0] sel(input logic m_hit, input logic w_hit);
    return m_hit ? 2'b10 : (w_hit ? 2'b01 : 2'b00);
  endfunction

  task automatic clear_inputs();
    bus.rs_d = '0; bus.rt_d = '0; bus.rs_e = '0; bus.rt_e = '0;
    bus.wreg_e = '0; bus.wreg_m = '0; bus.wreg_w = '0;
    bus.regwrite_e = 0; bus.regwrite_m = 0; bus.regwrite_w = 0;
    bus.memtoreg_e = 0; bus.memtoreg_m = 0;
    bus.branch_d = 0; bus.jumpr_d = 0;
    bus.md_op_d = 0; bus.md_read_d = 0; bus.md_start_e = 0;
    bus.dmem_req_m = 0; bus.dmem_ready_m = 0;
  endtask

  task automatic model_reset();
    busy_until = cycle - 1;
    wait_run = 0;
    err_m = 1'b0;
  endtask

  task automatic check_model();
    logic mw, ctrl, rt_used, lw, br, md, dec, busy;
    logic [1:0] ea, eb, da, db;
    logic sfd, sem, fe, fw, eb_busy, e_err;
    ea = 0; eb = 0; da = 0; db = 0; sfd = 0; sem = 0; fe = 0; fw = 0; eb_busy = 0; e_err = 0;
    if (rst_n) begin
      ea = sel(hit(bus.rs_e, bus.wreg_m, bus.regwrite_m), hit(bus.rs_e, bus.wreg_w, bus.regwrite_w));
      eb = sel(hit(bus.rt_e, bus.wreg_m, bus.regwrite_m), hit(bus.rt_e, bus.wreg_w, bus.regwrite_w));
      ctrl = bus.branch_d || bus.jumpr_d;
      if (ctrl)
        da = sel(hit(bus.rs_d, bus.wreg_m, bus.regwrite_m) && !bus.memtoreg_m,
                 hit(bus.rs_d, bus.wreg_w, bus.regwrite_w));
      if (bus.branch_d)
        db = sel(hit(bus.rt_d, bus.wreg_m, bus.regwrite_m) && !bus.memtoreg_m,
                 hit(bus.rt_d, bus.wreg_w, bus.regwrite_w));
      rt_used = !bus.jumpr_d;
      lw = bus.memtoreg_e && bus.wreg_e != 0 &&
           (bus.rs_d == bus.wreg_e || (rt_used && bus.rt_d == bus.wreg_e));
      br = ctrl && ((hit(bus.rs_d, bus.wreg_e, bus.regwrite_e) || hit(bus.rs_d, bus.wreg_m, bus.memtoreg_m)) ||
                    (rt_used && (hit(bus.rt_d, bus.wreg_e, bus.regwrite_e) ||
                                 hit(bus.rt_d, bus.wreg_m, bus.memtoreg_m))));
      busy = (cycle <= busy_until);
      md = (bus.md_op_d || bus.md_read_d) && (busy || bus.md_start_e);
      dec = lw || br || md;
      mw = bus.dmem_req_m && !bus.dmem_ready_m;
      sfd = mw || dec;
      sem = mw;
      fw = mw;
      fe = !mw && dec;
      eb_busy = busy;
      e_err = err_m;
    end
    chk1("stall_f", bus.stall_f, sfd);
    chk1("stall_d", bus.stall_d, sfd);
    chk1("stall_e", bus.stall_e, sem);
    chk1("stall_m", bus.stall_m, sem);
    chk1("flush_e", bus.flush_e, fe);
    chk1("flush_w", bus.flush_w, fw);
    chk2("fwd_a_e", bus.fwd_a_e, ea);
    chk2("fwd_b_e", bus.fwd_b_e, eb);
    chk2("fwd_a_d", bus.fwd_a_d, da);
    chk2("fwd_b_d", bus.fwd_b_d, db);
    chk1("md_busy", bus.md_busy, eb_busy);
    chk1("mem_err", bus.mem_err, e_err);
  endtask

  // Called at a negedge: compare, then advance the model across the next rising edge.
  task automatic tick();
    logic mw;
    check_model();
    @(posedge clk);
    if (rst_n) begin
      mw = bus.dmem_req_m && !bus.dmem_ready_m;
      if (bus.md_start_e && !mw) busy_until = cycle + LAT;
      if (mw) begin
        wait_run++;
        if (wait_run >= TMO) err_m = 1'b1;
      end else begin
        wait_run = 0;
      end
    end
    cycle++;
    #1;
  endtask

  initial begin
    clear_inputs();
    bus.dmem_req_m = 1; bus.rs_e = 5; bus.wreg_m = 5; bus.regwrite_m = 1; bus.md_read_d = 1; bus.md_start_e = 1;
    @(negedge clk);
    check_model();
    chk1("rst_stall_m", bus.stall_m, 1'b0);
    @(posedge clk); #1;
    rst_n = 1;
    clear_inputs();

    // E-stage forwarding priority
    bus.rs_e = 5; bus.wreg_m = 5; bus.wreg_w = 5; bus.regwrite_m = 1; bus.regwrite_w = 1;
    @(negedge clk); chk2("e_fwd_m", bus.fwd_a_e, 2'b10); tick();
    bus.regwrite_m = 0;
    @(negedge clk); chk2("e_fwd_w", bus.fwd_a_e, 2'b01); tick();
    bus.rs_e = 0;
    @(negedge clk); chk2("e_fwd_r0", bus.fwd_a_e, 2'b00); tick();
    clear_inputs();

    // Load-use: one bubble, then the load sits in M
    bus.memtoreg_e = 1; bus.regwrite_e = 1; bus.wreg_e = 8; bus.rt_d = 8; bus.rs_d = 1;
    @(negedge clk); chk1("lu_stall", bus.stall_d, 1'b1); chk1("lu_flush", bus.flush_e, 1'b1); tick();
    clear_inputs();
    bus.rt_d = 8; bus.rs_d = 1; bus.memtoreg_m = 1; bus.regwrite_m = 1; bus.wreg_m = 8;
    @(negedge clk); chk1("lu_release", bus.stall_d, 1'b0); tick();
    clear_inputs();

    // Branch after ALU producer, then after a load producer
    bus.branch_d = 1; bus.rs_d = 3; bus.wreg_e = 3; bus.regwrite_e = 1;
    @(negedge clk); chk1("br_alu_stall", bus.stall_f, 1'b1); tick();
    bus.wreg_e = 0; bus.regwrite_e = 0; bus.wreg_m = 3; bus.regwrite_m = 1;
    @(negedge clk); chk2("br_fwd_m", bus.fwd_a_d, 2'b10); chk1("br_alu_go", bus.stall_d, 1'b0); tick();
    bus.wreg_m = 0; bus.regwrite_m = 0;
    bus.wreg_e = 3; bus.regwrite_e = 1; bus.memtoreg_e = 1;
    @(negedge clk); chk1("br_ld_stall1", bus.stall_d, 1'b1); tick();
    bus.wreg_e = 0; bus.regwrite_e = 0; bus.memtoreg_e = 0;
    bus.wreg_m = 3; bus.regwrite_m = 1; bus.memtoreg_m = 1;
    @(negedge clk); chk1("br_ld_stall2", bus.stall_d, 1'b1); chk2("br_ld_nofwd", bus.fwd_a_d, 2'b00); tick();
    bus.wreg_m = 0; bus.regwrite_m = 0; bus.memtoreg_m = 0; bus.wreg_w = 3; bus.regwrite_w = 1;
    @(negedge clk); chk1("br_ld_go", bus.stall_d, 1'b0); chk2("br_fwd_w", bus.fwd_a_d, 2'b01); tick();
    clear_inputs();

    // Mult/div issue followed by a held mfhi
    bus.md_start_e = 1; bus.md_read_d = 1;
    @(negedge clk); chk1("md_issue_stall", bus.stall_d, 1'b1); chk1("md_issue_busy", bus.md_busy, 1'b0); tick();
    bus.md_start_e = 0;
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk); chk1("md_busy_run", bus.md_busy, 1'b1); chk1("md_stall_run", bus.stall_d, 1'b1); tick();
    end
    @(negedge clk); chk1("md_done", bus.md_busy, 1'b0); chk1("md_release", bus.stall_d, 1'b0); tick();
    clear_inputs();

    // Memory wait with watchdog
    bus.dmem_req_m = 1; bus.dmem_ready_m = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1("mw_stall_m", bus.stall_m, 1'b1); chk1("mw_flush_w", bus.flush_w, 1'b1);
      chk1("mw_err", bus.mem_err, (i >= TMO) ? 1'b1 : 1'b0);
      tick();
    end
    bus.dmem_ready_m = 1;
    @(negedge clk); chk1("mw_ready", bus.stall_m, 1'b0); chk1("mw_err_sticky", bus.mem_err, 1'b1); tick();
    clear_inputs();

    // Asynchronous reset with HI/LO count at 2 and the error flag set
    bus.md_start_e = 1;
    @(negedge clk); tick();
    bus.md_start_e = 0;
    @(negedge clk); tick();
    @(negedge clk); tick();
    chk1("pre_rst_busy", bus.md_busy, 1'b1);
    chk1("pre_rst_err", bus.mem_err, 1'b1);
    rst_n = 0;
    model_reset();
    bus.dmem_req_m = 1; bus.rs_e = 5; bus.wreg_m = 5; bus.regwrite_m = 1;
    #1;
    chk1("arst_stall_f", bus.stall_f, 1'b0);
    chk2("arst_fwd", bus.fwd_a_e, 2'b00);
    chk1("arst_busy", bus.md_busy, 1'b0);
    chk1("arst_err", bus.mem_err, 1'b0);
    check_model();
    #1;
    rst_n = 1;
    clear_inputs();
    @(negedge clk); chk1("post_rst_busy", bus.md_busy, 1'b0); chk1("post_rst_err", bus.mem_err, 1'b0); tick();

    // Randomized pipeline fields against the reference model
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        rst_n = 0;
        model_reset();
        #1;
        check_model();
        rst_n = 1;
      end
      bus.rs_d = AW'($urandom_range(0, 3)); bus.rt_d = AW'($urandom_range(0, 3));
      bus.rs_e = AW'($urandom_range(0, 3)); bus.rt_e = AW'($urandom_range(0, 3));
      bus.wreg_e = AW'($urandom_range(0, 3)); bus.wreg_m = AW'($urandom_range(0, 3));
      bus.wreg_w = AW'($urandom_range(0, 3));
      bus.regwrite_e = 1'($urandom_range(0, 1)); bus.regwrite_m = 1'($urandom_range(0, 1));
      bus.regwrite_w = 1'($urandom_range(0, 1));
      bus.memtoreg_e = 1'($urandom_range(0, 1)); bus.memtoreg_m = 1'($urandom_range(0, 1));
      bus.branch_d = ($urandom_range(0, 2) == 0); bus.jumpr_d = ($urandom_range(0, 3) == 0);
      bus.md_op_d = ($urandom_range(0, 5) == 0); bus.md_read_d = ($urandom_range(0, 3) == 0);
      bus.md_start_e = ($urandom_range(0, 9) == 0);
      bus.dmem_req_m = 1'($urandom_range(0, 1)); bus.dmem_ready_m = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
